csl_addsub_seq: RTL and testbench
=================================

Name: csl_addsub_seq

Overview:
- Multi-cycle W-bit adder/subtractor that walks the operands CHUNK bits per cycle, least significant chunk first.
- Each chunk uses a carry-select block: both carry-in cases are computed in parallel and the registered inter-chunk carry selects one.
- This is the sequenced counterpart of the single-cycle bit-level carry-select cell, for area-limited datapaths.
- Operands arrive on a valid/ready request port; the result leaves on a valid/ready response port.

Parameters:
- W, 16, operand and result width in bits.
- CHUNK, 4, bits processed per cycle. W must be a multiple of CHUNK.
- NCHUNK, W/CHUNK, number of chunk cycles. This is a derived localparam and must not be overridden.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- a  in  W  operand A.
- b  in  W  operand B.
- sub  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W  sum or difference, modulo 2^W.
- cout  out  1  carry out of the MSB. For subtraction, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising clk edge. After reset:
  - state = IDLE, in_ready = 1, out_valid = 0;
  - result = 0, cout = 0, ovf = 0;
  - chunk counter = 0, carry register = 0.
- Reset mid-operation aborts immediately. No partial result is ever presented.
- FSM, three states:
  - IDLE: in_ready = 1. On an edge where in_valid is high, capture a, b ^ {W{sub}} and sub. Set carry register = sub, counter = 0. Go to BUSY. In_valid low: stay in IDLE.
  - BUSY: in_ready = 0. On each edge, process chunk k = counter:
    - compute s0/c0 with carry-in 0 and s1/c1 with carry-in 1;
    - select by the carry register;
    - write result[k*CHUNK +: CHUNK] and update the carry register;
    - increment the counter.
    - On the edge that processes k = NCHUNK-1: also latch cout = final carry and ovf = (A[W-1] == B'[W-1]) && (result MSB != A[W-1]), where B' is the inverted-if-sub operand. Set out_valid = 1 and go to DONE.
  - DONE: in_ready = 0, out_valid = 1. Result, cout and ovf are held stable. On an edge with out_ready high, clear out_valid and return to IDLE. Result, cout and ovf keep their values until the next accept.
- Latency:
  - accept edge E0;
  - chunks are written on edges E1..E_NCHUNK;
  - out_valid is high after E_NCHUNK (4 cycles at defaults).
  - Minimum initiation interval is NCHUNK+2 cycles with out_ready tied high.
- Backpressure: out_ready may stay low indefinitely. No new request is accepted while in DONE.
- Inputs a, b and sub are sampled only on the accept edge. Changes during BUSY or DONE have no effect.
- While in IDLE, out_ready is ignored.
- Arithmetic:
  - result equals (A + (sub ? ~B : B) + sub) mod 2^W.
  - cout is bit W of that sum.
  - Boundary cases: FFFF+0001 wraps to 0000 with cout = 1. 0-0 with sub gives cout = 1.
- Elaboration must fail if W % CHUNK != 0 or CHUNK < 1.

Decomposition:
- Shared package, holding:
  - state encoding: IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  - the ADD = 1'b0 / SUB = 1'b1 mode constants.
- One sub-module, csl_chunk: purely combinational, CHUNK-bit carry-select block.
  - Inputs: x, y, cin. Outputs: sum, cout.
  - Internally holds two ripple adders for cin = 0 and cin = 1, plus the selecting muxes.
  - Instantiated once, reused every cycle.
- The FSM, counter, carry register and handshake live in csl_addsub_seq.

Test Plan (all at defaults W = 16, CHUNK = 4):
- Add: a=1234, b=0FFF, sub=0 → result 2233, cout 0, ovf 0. out_valid rises exactly 4 edges after the accept edge.
- Positive overflow: a=7FFF, b=0001, sub=0 → result 8000, cout 0, ovf 1. Wrap: a=FFFF, b=0001, sub=0 → result 0000, cout 1, ovf 0.
- Subtract with borrow: a=0005, b=0007, sub=1 → result FFFE, cout 0, ovf 0. Negative overflow: a=8000, b=0001, sub=1 → result 7FFF, cout 1, ovf 1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result, cout and ovf stable, in_ready 0. Pulsing in_valid during this window is ignored. Raising out_ready → IDLE the next cycle.
- Reset mid-BUSY: assert rst on the second chunk edge → next cycle in_ready 1, out_valid 0, result 0000, cout 0, ovf 0. A fresh request then completes correctly.
- Randomised back-to-back: 1000 random a, b, sub with random out_ready stalls → every result, cout and ovf matches the reference model, and exactly one response is produced per accepted request.

Source files
------------

// File: rtl/csl_addsub_seq_pkg.sv
// Shared definitions for the sequenced carry-select adder/subtractor:
// FSM state encoding and operation mode constants.
package csl_addsub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/csl_chunk.sv
// CHUNK-bit carry-select block: two ripple adders (carry-in 0 and 1) run in
// parallel and the real carry-in picks one sum/carry pair.
module csl_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK-1:0] s0, s1;
    logic             c0, c1;

    always_comb begin
        s0 = '0;
        s1 = '0;
        c0 = 1'b0;
        c1 = 1'b1;
        for (int i = 0; i < CHUNK; i++) begin
            s0[i] = x[i] ^ y[i] ^ c0;
            c0    = (x[i] & y[i]) | (c0 & (x[i] ^ y[i]));
            s1[i] = x[i] ^ y[i] ^ c1;
            c1    = (x[i] & y[i]) | (c1 & (x[i] ^ y[i]));
        end
    end

    assign sum  = cin ? s1 : s0;
    assign cout = cin ? c1 : c0;

endmodule

// File: rtl/csl_addsub_seq.sv
// Multi-cycle W-bit adder/subtractor: one CHUNK-bit carry-select slice per
// cycle, LSB chunk first, with valid/ready request and response ports.
module csl_addsub_seq
    import csl_addsub_seq_pkg::*;
#(
    parameter int W     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf
);

    localparam int NCHUNK = W / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || (W % CHUNK) != 0) begin : g_bad_params
            $error("csl_addsub_seq: W must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [CHUNK-1:0] x, y, s;
    logic             c;

    assign x = a_r[cnt*CHUNK +: CHUNK];
    assign y = b_r[cnt*CHUNK +: CHUNK];

    csl_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x    (x),
        .y    (y),
        .cin  (carry),
        .sum  (s),
        .cout (c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B once here, feed the +1 as carry-in.
                        a_r      <= a;
                        b_r      <= (sub == ADD) ? b : ~b;
                        carry    <= (sub == SUB);
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    result[cnt*CHUNK +: CHUNK] <= s;
                    carry <= c;
                    if (cnt == LAST) begin
                        // Top chunk's sum MSB is the result MSB, so overflow is known this edge.
                        cout      <= c;
                        ovf       <= (a_r[W-1] == b_r[W-1]) && (s[CHUNK-1] != a_r[W-1]);
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csl_addsub_seq.sv
// Scoreboard bench for csl_addsub_seq: stimulus pushes expected responses,
// a monitor pops and compares on every accepted output.
module tb_csl_addsub_seq;

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        cout;
    logic        ovf;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_push = 0;
    int   n_pop = 0;
    bit   rnd_rdy = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    csl_addsub_seq #(.W(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Monitor: a response is consumed on the next rising edge when valid and ready are both high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 32'(result), 32'hDEAD);
                end else begin
                    e = sb.pop_front();
                    n_pop++;
                    chk("resp_result", 32'(result), 32'(e.res));
                    chk("resp_cout", 32'(cout), 32'(e.co));
                    chk("resp_ovf", 32'(ovf), 32'(e.ov));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                        input logic [15:0] er, input logic ec, input logic eo, input bit push);
        exp_t e;
        int   t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        a = va;
        b = vb;
        sub = vs;
        in_valid = 1'b1;
        if (push) begin
            e.res = er;
            e.co = ec;
            e.ov = eo;
            sb.push_back(e);
            n_push++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom();
        b = $urandom();
        sub = $urandom_range(0, 1);
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    initial begin
        int          k;
        logic [15:0] ra, rb, bb, er;
        logic        rs, ec, eo;
        logic [16:0] full;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // Directed vectors with latency check on the first.
        send(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b1);
        wait_valid(k);
        chk("latency", 32'(k), 32'd4);
        send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        send(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Backpressure: hold the result, ignore new requests.
        wait_valid(k);
        while (in_ready == 1'b0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
        wait_valid(k);
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 16'hABCD;
            b = 16'h1234;
            @(posedge clk);
            #1;
            chk("bp_result", 32'(result), 32'h3333);
            chk("bp_flags", 32'({cout, ovf}), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Reset sampled on the second chunk edge.
        send(16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_flags", 32'({cout, ovf}), 32'd0);
        send(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);

        // Randomised back-to-back with random stalls.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = $urandom();
            rs = $urandom_range(0, 1);
            bb = rs ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, bb} + {16'd0, rs};
            er = full[15:0];
            ec = full[16];
            eo = (ra[15] == bb[15]) && (er[15] != ra[15]);
            send(ra, rb, rs, er, ec, eo, 1'b1);
        end

        k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        chk("resp_count", 32'(n_pop), 32'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
